// File: rtl/cpu_pkg.sv
// Shared CPU definitions.
// MEM-stage FSM encoding and data-memory timeout defaults.
package cpu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } mem_state_e;

   localparam int TIMEOUT_DEF = 15;
   localparam int CNT_W       = 4;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Wait-cycle counter for the MEM-stage memory access.
// tc flags the last WAIT cycle allowed before the access is aborted.
module mem_timeout_cnt
   import cpu_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tc
);

   logic [CNT_W-1:0] cnt;

   // count WAIT cycles; cleared whenever no access is waiting
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en)
         cnt <= cnt + CNT_W'(1);
   end

   assign tc = (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage data-memory controller.
// Stalls the pipeline while a load/store waits for the memory ack.
module mem_stage_ctrl
   import cpu_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Mem_MemRead,
   input  logic        Mem_MemWrite,
   input  logic        Mem_RegWrite,
   input  logic [1:0]  Mem_MemtoReg,
   input  logic [31:0] Mem_ALUout,
   input  logic [31:0] Mem_WriteData,
   input  logic [31:0] Mem_WriteAddress,
   input  logic [31:0] Mem_PCjia4,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        stall,
   output logic        Wb_RegWrite,
   output logic [1:0]  Wb_MemtoReg,
   output logic [31:0] Wb_ReadData,
   output logic [31:0] Wb_ALUout,
   output logic [31:0] Wb_WriteAddress,
   output logic [31:0] Wb_PCjia4,
   output logic        addr_err,
   output logic        bus_err
);

   mem_state_e  state;
   mem_state_e  state_nx;
   logic        access;
   logic        aligned;
   logic        start;
   logic        fin_ack;
   logic        fin_tmo;
   logic        in_wait;
   logic        tc;
   logic [31:0] rdata_q;

   assign access  = Mem_MemRead | Mem_MemWrite;
   assign aligned = (Mem_ALUout[1:0] == 2'b00);
   assign in_wait = (state == WAIT);

   mem_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_tmo (
      .clk   (clk),
      .reset (reset),
      .clr   (!in_wait),
      .en    (in_wait),
      .tc    (tc)
   );

   // next-state, stall and error decode
   always_comb begin
      state_nx = state;
      stall    = 1'b0;
      addr_err = 1'b0;
      start    = 1'b0;
      fin_ack  = 1'b0;
      fin_tmo  = 1'b0;
      unique case (state)
         IDLE: begin
            if (access) begin
               if (aligned) begin
                  state_nx = WAIT;
                  stall    = 1'b1;
                  start    = 1'b1;
               end else begin
                  addr_err = 1'b1;
               end
            end
         end
         WAIT: begin
            stall = 1'b1;
            if (dmem_ack) begin
               state_nx = DONE;
               fin_ack  = 1'b1;
            end else if (tc) begin
               state_nx = DONE;
               fin_tmo  = 1'b1;
            end
         end
         DONE: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // request capture, read-data latch and timeout flag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         rdata_q    <= '0;
         bus_err    <= 1'b0;
      end else begin
         if (start) begin
            dmem_we    <= Mem_MemWrite;
            dmem_addr  <= Mem_ALUout;
            dmem_wdata <= Mem_WriteData;
         end
         if (fin_ack)
            rdata_q <= dmem_we ? '0 : dmem_rdata;
         else if (fin_tmo)
            rdata_q <= '0;
         bus_err <= fin_tmo;
      end
   end

   assign dmem_req        = in_wait;
   assign Wb_ReadData     = rdata_q;
   assign Wb_RegWrite     = Mem_RegWrite & ~addr_err & ~bus_err;
   assign Wb_MemtoReg     = Mem_MemtoReg;
   assign Wb_ALUout       = Mem_ALUout;
   assign Wb_WriteAddress = Mem_WriteAddress;
   assign Wb_PCjia4       = Mem_PCjia4;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Testbench for mem_stage_ctrl.
// Random accesses against a per-access outcome model and scoreboard.
module tb_mem_stage_ctrl;

   localparam int TO = 15;

   logic        clk = 1'b0;
   logic        reset;
   logic        Mem_MemRead;
   logic        Mem_MemWrite;
   logic        Mem_RegWrite;
   logic [1:0]  Mem_MemtoReg;
   logic [31:0] Mem_ALUout;
   logic [31:0] Mem_WriteData;
   logic [31:0] Mem_WriteAddress;
   logic [31:0] Mem_PCjia4;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;
   logic        stall;
   logic        Wb_RegWrite;
   logic [1:0]  Wb_MemtoReg;
   logic [31:0] Wb_ReadData;
   logic [31:0] Wb_ALUout;
   logic [31:0] Wb_WriteAddress;
   logic [31:0] Wb_PCjia4;
   logic        addr_err;
   logic        bus_err;

   always #5 clk = ~clk;

   mem_stage_ctrl #(
      .TIMEOUT (TO)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .Mem_MemRead      (Mem_MemRead),
      .Mem_MemWrite     (Mem_MemWrite),
      .Mem_RegWrite     (Mem_RegWrite),
      .Mem_MemtoReg     (Mem_MemtoReg),
      .Mem_ALUout       (Mem_ALUout),
      .Mem_WriteData    (Mem_WriteData),
      .Mem_WriteAddress (Mem_WriteAddress),
      .Mem_PCjia4       (Mem_PCjia4),
      .dmem_req         (dmem_req),
      .dmem_we          (dmem_we),
      .dmem_addr        (dmem_addr),
      .dmem_wdata       (dmem_wdata),
      .dmem_rdata       (dmem_rdata),
      .dmem_ack         (dmem_ack),
      .stall            (stall),
      .Wb_RegWrite      (Wb_RegWrite),
      .Wb_MemtoReg      (Wb_MemtoReg),
      .Wb_ReadData      (Wb_ReadData),
      .Wb_ALUout        (Wb_ALUout),
      .Wb_WriteAddress  (Wb_WriteAddress),
      .Wb_PCjia4        (Wb_PCjia4),
      .addr_err         (addr_err),
      .bus_err          (bus_err)
   );

   typedef struct {
      bit          rd;
      bit          wr;
      bit          rw;
      logic [1:0]  m2r;
      logic [31:0] alu;
      logic [31:0] wdat;
      logic [31:0] waddr;
      logic [31:0] pc;
      logic [31:0] rdat;
      int          k;
   } txn_t;

   typedef struct {
      int          stall_n;
      int          req_n;
      int          edges;
      int          be_n;
      bit          be;
      bit          ae;
      bit          rwo;
      bit          chk_req;
      logic [31:0] rdo;
      logic [31:0] addr;
      logic [31:0] wdata;
      bit          we;
      logic [1:0]  m2r;
      logic [31:0] alu;
      logic [31:0] waddr;
      logic [31:0] pc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   bit   in_valid = 1'b0;

   // Outcome of one instruction, from the access rules.
   function automatic exp_t model(txn_t t);
      exp_t e;
      e = '{default: 0};
      e.m2r   = t.m2r;
      e.alu   = t.alu;
      e.waddr = t.waddr;
      e.pc    = t.pc;
      e.rwo   = t.rw;
      if (t.rd || t.wr) begin
         if (t.alu % 4 != 0) begin
            e.ae  = 1;
            e.rwo = 0;
         end else begin
            e.chk_req = 1;
            e.edges   = 1;
            e.addr    = t.alu;
            e.wdata   = t.wdat;
            e.we      = t.wr;
            if (t.k < TO) begin
               e.stall_n = t.k + 2;
               e.req_n   = t.k + 1;
               e.rdo     = t.wr ? 32'h0 : t.rdat;
            end else begin
               e.stall_n = TO + 1;
               e.req_n   = TO;
               e.rdo     = 32'h0;
               e.be_n    = 1;
               e.be      = 1;
               e.rwo     = 0;
            end
         end
      end
      return e;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic finish_up();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   endtask

   // Monitor: accumulate per-instruction observations, compare at retire.
   initial begin
      int          a_stall;
      int          a_req;
      int          a_edges;
      int          a_be;
      int          a_unst;
      bit          prev_req;
      bit          a_got;
      logic [31:0] a_addr;
      logic [31:0] a_wdata;
      logic        a_we;
      exp_t        e;
      a_stall = 0; a_req = 0; a_edges = 0; a_be = 0; a_unst = 0;
      prev_req = 0; a_got = 0;
      a_addr = '0; a_wdata = '0; a_we = 1'b0;
      forever begin
         @(negedge clk);
         if (in_valid) begin
            if (stall) a_stall++;
            if (bus_err) a_be++;
            if (dmem_req) begin
               a_req++;
               if (!prev_req) a_edges++;
               if (!a_got) begin
                  a_got   = 1;
                  a_addr  = dmem_addr;
                  a_wdata = dmem_wdata;
                  a_we    = dmem_we;
               end else if (a_addr !== dmem_addr ||
                            a_wdata !== dmem_wdata ||
                            a_we !== dmem_we) begin
                  a_unst++;
               end
            end
            prev_req = dmem_req;
            if (!stall) begin
               if (sb.size() == 0) begin
                  chk("sb_empty", 32'(sb.size()), 32'd1);
               end else begin
                  e = sb.pop_front();
                  chk("stall_cycles", 32'(a_stall), 32'(e.stall_n));
                  chk("req_cycles", 32'(a_req), 32'(e.req_n));
                  chk("req_count", 32'(a_edges), 32'(e.edges));
                  chk("bus_err_cycles", 32'(a_be), 32'(e.be_n));
                  chk("bus_err", 32'(bus_err), 32'(e.be));
                  chk("addr_err", 32'(addr_err), 32'(e.ae));
                  chk("wb_regwrite", 32'(Wb_RegWrite), 32'(e.rwo));
                  chk("wb_memtoreg", 32'(Wb_MemtoReg), 32'(e.m2r));
                  chk("wb_aluout", Wb_ALUout, e.alu);
                  chk("wb_waddr", Wb_WriteAddress, e.waddr);
                  chk("wb_pc", Wb_PCjia4, e.pc);
                  if (e.chk_req) begin
                     chk("dmem_addr", a_addr, e.addr);
                     chk("dmem_wdata", a_wdata, e.wdata);
                     chk("dmem_we", 32'(a_we), 32'(e.we));
                     chk("req_stable", 32'(a_unst), 32'd0);
                     chk("wb_readdata", Wb_ReadData, e.rdo);
                  end
               end
               a_stall = 0; a_req = 0; a_edges = 0; a_be = 0; a_unst = 0;
               a_got = 0; prev_req = 0;
            end
         end
      end
   end

   task automatic clear_inputs();
      Mem_MemRead      = 1'b0;
      Mem_MemWrite     = 1'b0;
      Mem_RegWrite     = 1'b0;
      Mem_MemtoReg     = 2'b00;
      Mem_ALUout       = '0;
      Mem_WriteData    = '0;
      Mem_WriteAddress = '0;
      Mem_PCjia4       = '0;
      dmem_ack         = 1'b0;
      dmem_rdata       = '0;
   endtask

   function automatic txn_t mk(bit rd, bit wr, bit rw, logic [31:0] alu,
                               logic [31:0] wdat, logic [31:0] rdat, int k);
      txn_t t;
      t.rd    = rd;
      t.wr    = wr;
      t.rw    = rw;
      t.m2r   = 2'($urandom_range(3));
      t.alu   = alu;
      t.wdat  = wdat;
      t.waddr = 32'($urandom_range(31));
      t.pc    = $urandom & 32'hFFFF_FFFC;
      t.rdat  = rdat;
      t.k     = k;
      return t;
   endfunction

   // Drive one instruction and play the memory until it retires.
   task automatic run(txn_t t);
      int idx;
      int cyc;
      bit done;
      idx  = 0;
      cyc  = 0;
      done = 0;
      sb.push_back(model(t));
      @(posedge clk); #1;
      Mem_MemRead      = t.rd;
      Mem_MemWrite     = t.wr;
      Mem_RegWrite     = t.rw;
      Mem_MemtoReg     = t.m2r;
      Mem_ALUout       = t.alu;
      Mem_WriteData    = t.wdat;
      Mem_WriteAddress = t.waddr;
      Mem_PCjia4       = t.pc;
      in_valid         = 1'b1;
      while (!done) begin
         if (dmem_req) begin
            dmem_ack   = (idx == t.k);
            dmem_rdata = (idx == t.k) ? t.rdat : $urandom;
            idx++;
         end else begin
            dmem_ack   = ($urandom_range(3) == 0);
            dmem_rdata = $urandom;
         end
         @(negedge clk);
         if (!stall) begin
            done = 1;
         end else begin
            cyc++;
            if (cyc > 40) begin
               checks++;
               errors++;
               $display("FAIL stall_bound act=%0d exp<=%0d", cyc, 40);
               finish_up();
            end
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic check_idle_outputs(string tag);
      chk({tag, "_req"}, 32'(dmem_req), 32'd0);
      chk({tag, "_we"}, 32'(dmem_we), 32'd0);
      chk({tag, "_addr"}, dmem_addr, 32'd0);
      chk({tag, "_wdata"}, dmem_wdata, 32'd0);
      chk({tag, "_rdata"}, Wb_ReadData, 32'd0);
      chk({tag, "_stall"}, 32'(stall), 32'd0);
      chk({tag, "_bus_err"}, 32'(bus_err), 32'd0);
      chk({tag, "_addr_err"}, 32'(addr_err), 32'd0);
   endtask

   initial begin
      txn_t        t;
      int          kind;
      int          reqs;
      logic [31:0] a;
      clear_inputs();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      @(negedge clk);
      reset = 1'b1;

      run(mk(1, 0, 1, 32'h10, 32'h0, 32'hDEAD_BEEF, 3));
      run(mk(0, 1, 0, 32'h20, 32'h1234_5678, 32'hCAFE_F00D, 0));
      run(mk(1, 0, 1, 32'h13, 32'h0, 32'h1111_1111, 0));
      run(mk(1, 0, 1, 32'h40, 32'h0, 32'h2222_2222, 99));
      run(mk(1, 0, 1, 32'h44, 32'h0, 32'h3333_3333, TO - 1));
      run(mk(1, 1, 1, 32'h48, 32'hA5A5_5A5A, 32'h4444_4444, 2));
      run(mk(0, 0, 1, 32'h51, 32'h0, 32'h0, 0));

      // reset in the second WAIT cycle of a load
      @(posedge clk); #1;
      in_valid     = 1'b0;
      Mem_MemRead  = 1'b1;
      Mem_RegWrite = 1'b1;
      Mem_ALUout   = 32'h80;
      dmem_ack     = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rst_pre_req", 32'(dmem_req), 32'd1);
      clear_inputs();
      reset = 1'b0;
      #1;
      check_idle_outputs("rst_wait");
      @(posedge clk); #1;
      reset = 1'b1;
      reqs  = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (dmem_req) reqs++;
      end
      chk("rst_no_retry", 32'(reqs), 32'd0);
      check_idle_outputs("rst_after");

      for (int n = 0; n < 80; n++) begin
         kind = $urandom_range(3);
         a    = $urandom;
         if ($urandom_range(3) != 0) a = a & 32'hFFFF_FFFC;
         t = mk(kind == 1 || kind == 3, kind >= 2, 1'($urandom),
                a, $urandom, $urandom,
                ($urandom_range(3) == 0) ? $urandom_range(TO - 2, TO + 2)
                                         : $urandom_range(0, 5));
         run(t);
      end

      @(posedge clk); #1;
      in_valid = 1'b0;
      clear_inputs();
      repeat (3) @(posedge clk);
      chk("sb_drain", 32'(sb.size()), 32'd0);
      finish_up();
   end

endmodule
